// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache block memory arbiter; optional round-robin tie-break under MEM_ARB_RR_EN
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy
);

  typedef enum logic [2:0] {IDLE, I_XFER, D_XFER, I_DONE, D_DONE} state_t;

  state_t state;
  state_t state_nx;
  logic   i_req;
  logic   d_req;
  logic   d_win;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant_d;

  // Remember which side completed last so that ties alternate between the caches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b0;
    end else if (state == D_DONE) begin
      last_grant_d <= 1'b1;
    end else if (state == I_DONE) begin
      last_grant_d <= 1'b0;
    end
  end

  assign d_win = d_req & (~i_req | ~last_grant_d);
`else
  assign d_win = d_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: grant in IDLE, wait for memory in XFER, single DONE cycle back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (d_win) begin
          state_nx = D_XFER;
        end else if (i_req) begin
          state_nx = I_XFER;
        end
      end
      I_XFER:  if (mem_ready) state_nx = I_DONE;
      D_XFER:  if (mem_ready) state_nx = D_DONE;
      I_DONE:  state_nx = IDLE;
      D_DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs: latch the winning request, capture read data, pulse ready on DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      arb_busy    <= 1'b0;
    end else begin
      i_mem_ready <= (state_nx == I_DONE);
      d_mem_ready <= (state_nx == D_DONE);
      arb_busy    <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          // A combined read+write request is issued as a write only
          if (d_win) begin
            mem_addr  <= d_mem_addr;
            mem_wdata <= d_mem_wdata;
            mem_write <= d_mem_write;
            mem_read  <= d_mem_read & ~d_mem_write;
          end else if (i_req) begin
            mem_addr  <= i_mem_addr;
            mem_wdata <= i_mem_wdata;
            mem_write <= i_mem_write;
            mem_read  <= i_mem_read & ~i_mem_write;
          end
        end
        I_XFER: begin
          if (mem_ready) begin
            if (mem_read) i_mem_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        D_XFER: begin
          if (mem_ready) begin
            if (mem_read) d_mem_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  localparam logic [DW-1:0] A5   = {16{8'hA5}};
  localparam logic [DW-1:0] D20  = {4{32'h2020_0020}};
  localparam logic [DW-1:0] D40  = {4{32'h4040_0040}};
  localparam logic [DW-1:0] D60  = {4{32'h6060_0060}};
  localparam logic [DW-1:0] D70  = {4{32'h7070_0070}};
  localparam logic [DW-1:0] D80  = {4{32'h8080_0080}};
  localparam logic [DW-1:0] WI   = {4{32'h1111_0001}};
  localparam logic [DW-1:0] WD0  = {4{32'h0D0D_0000}};
  localparam logic [DW-1:0] WD30 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
  localparam logic [DW-1:0] WD50 = {4{32'hCAFE_0050}};
  localparam logic [DW-1:0] BAD  = {4{32'hBAD0_0BAD}};

  localparam int P_IDLE = 1;
  localparam int P_RD   = 2;
  localparam int P_TOUT = 3;
  localparam int P_DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [DW-1:0] i_mem_wdata = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [DW-1:0] d_mem_wdata = '0;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          arb_busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { bit side_d; logic [DW-1:0] rdata; } rsp_exp_t;
  mem_exp_t mq[$];
  rsp_exp_t rq[$];

  int n_vec = 0, n_err = 0;
  int mem_lat = 3;
  int stray_req = 0;
  int probe_req = 0, probe_code = 0;
  bit i_rdy_q = 1'b0, d_rdy_q = 1'b0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      28'h10:  return A5;
      28'h20:  return D20;
      28'h40:  return D40;
      28'h60:  return D60;
      28'h70:  return D70;
      28'h80:  return D80;
      default: return '0;
    endcase
  endfunction

  // Memory model: answers a strobe after mem_lat cycles with a one-cycle mem_ready
  int mem_cnt = 0;
  int stray_ack = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ready = 1'b0;
      mem_cnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (stray_req != stray_ack) begin
      stray_ack = stray_req;
      mem_ready = 1'b1;
      mem_rdata = BAD;
    end else if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_cnt = 0;
        mem_ready = 1'b1;
        mem_rdata = mem_write ? BAD : mem_val(mem_addr);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Monitor / scoreboard: all comparisons are made here, at the falling edge
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  bit            prev_strobe = 1'b0, mr_prev = 1'b0, idle_next = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] exp_i = '0, exp_d = '0;
  int            probe_ack = 0;
  always @(negedge clk) begin
    mem_exp_t e;
    rsp_exp_t r;
    i_rdy_q = i_mem_ready;
    d_rdy_q = d_mem_ready;
    if (!rst_n) begin
      chk("reset_ctl", {arb_busy, mem_read, mem_write, i_mem_ready, d_mem_ready}, '0);
      chk("reset_data", {mem_addr, mem_wdata} | i_mem_rdata | d_mem_rdata, '0);
      prev_strobe = 1'b0; mr_prev = 1'b0; idle_next = 1'b0;
      exp_i = '0; exp_d = '0;
    end else begin
      chk("strobe_excl", mem_read & mem_write, 0);
      if (idle_next) begin
        chk("idle_after_done", {arb_busy, mem_read, mem_write}, 0);
        idle_next = 1'b0;
      end
      if ((mem_read || mem_write) && !prev_strobe) begin
        if (mq.size() == 0) begin
          chk("unexpected_strobe", {mem_write, mem_read}, 0);
        end else begin
          e = mq.pop_front();
          chk("mem_op", {mem_write, mem_read}, e.op);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        hold_addr = mem_addr;
      end else if (mem_read || mem_write) begin
        chk("addr_hold", mem_addr, hold_addr);
      end
      if (mem_read || mem_write) chk("busy_in_xfer", arb_busy, 1);
      if (i_mem_ready || d_mem_ready) begin
        chk("ready_latency", mr_prev, 1);
        chk("ready_one_side", i_mem_ready & d_mem_ready, 0);
        if (rq.size() == 0) begin
          chk("unexpected_ready", {i_mem_ready, d_mem_ready}, 0);
        end else begin
          r = rq.pop_front();
          chk("ready_side", d_mem_ready, r.side_d);
          if (r.side_d) exp_d = r.rdata;
          else exp_i = r.rdata;
        end
        chk("i_rdata", i_mem_rdata, exp_i);
        chk("d_rdata", d_mem_rdata, exp_d);
        idle_next = 1'b1;
      end
      prev_strobe = mem_read || mem_write;
      mr_prev = mem_ready;
    end
    if (probe_req != probe_ack) begin
      probe_ack = probe_req;
      case (probe_code)
        P_IDLE: begin
          chk("probe_idle", {arb_busy, mem_read, mem_write, i_mem_ready, d_mem_ready}, 0);
          chk("probe_rdata", {i_mem_rdata, d_mem_rdata}, {exp_i, exp_d});
        end
        P_RD:   chk("probe_strobe", {arb_busy, mem_read, mem_write}, 3'b110);
        P_TOUT: chk("service_timeout", 1, 0);
        P_DRAIN: begin
          chk("mq_drained", mq.size(), 0);
          chk("rq_drained", rq.size(), 0);
        end
        default: ;
      endcase
    end
  end

  task automatic probe(input int code);
    probe_code = code;
    probe_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic exp_mem(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    mem_exp_t e;
    e.op = op; e.addr = a; e.wdata = wd;
    mq.push_back(e);
  endtask

  task automatic exp_rsp(input bit side_d, input logic [DW-1:0] rd);
    rsp_exp_t r;
    r.side_d = side_d; r.rdata = rd;
    rq.push_back(r);
  endtask

  // Requester behaviour: drop a request on the edge that samples its ready pulse
  task automatic service(input int want, input bit hold);
    int n;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < want; cyc++) begin
      @(posedge clk);
      #1;
      if (i_rdy_q) begin
        n++;
        if (!hold) begin i_mem_read = 1'b0; i_mem_write = 1'b0; end
      end
      if (d_rdy_q) begin
        n++;
        if (!hold) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      end
      if (hold && n >= want) begin
        i_mem_read = 1'b0; i_mem_write = 1'b0;
        d_mem_read = 1'b0; d_mem_write = 1'b0;
      end
    end
    if (n < want) probe(P_TOUT);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // I read alone with a 5-cycle memory
    mem_lat = 5;
    exp_mem(2'b01, 28'h10, WI);
    exp_rsp(1'b0, A5);
    i_mem_addr = 28'h10; i_mem_wdata = WI; i_mem_read = 1'b1;
    probe(P_IDLE);
    probe(P_RD);
    service(1, 1'b0);

    // Simultaneous I and D reads: D first, then I
    mem_lat = 3;
    exp_mem(2'b01, 28'h20, WD0);
    exp_mem(2'b01, 28'h10, WI);
    exp_rsp(1'b1, D20);
    exp_rsp(1'b0, A5);
    d_mem_addr = 28'h20; d_mem_wdata = WD0; d_mem_read = 1'b1;
    i_mem_read = 1'b1;
    service(2, 1'b0);

    // D writeback then D read
    exp_mem(2'b10, 28'h30, WD30);
    exp_rsp(1'b1, D20);
    d_mem_addr = 28'h30; d_mem_wdata = WD30; d_mem_write = 1'b1;
    service(1, 1'b0);
    exp_mem(2'b01, 28'h40, WD30);
    exp_rsp(1'b1, D40);
    d_mem_addr = 28'h40; d_mem_read = 1'b1;
    service(1, 1'b0);

    // D read+write together is issued as a write
    mem_lat = 2;
    exp_mem(2'b10, 28'h50, WD50);
    exp_rsp(1'b1, D40);
    d_mem_addr = 28'h50; d_mem_wdata = WD50; d_mem_read = 1'b1; d_mem_write = 1'b1;
    service(1, 1'b0);

    // Stray mem_ready in IDLE is ignored
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    probe(P_IDLE);

    // Reset in the third D_XFER cycle, then a held I request
    mem_lat = 10;
    exp_mem(2'b01, 28'h60, WD50);
    @(posedge clk); #1;
    d_mem_addr = 28'h60; d_mem_read = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    d_mem_read = 1'b0;
    mem_lat = 3;
    exp_mem(2'b01, 28'h10, WI);
    exp_rsp(1'b0, A5);
    i_mem_addr = 28'h10; i_mem_read = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    service(1, 1'b0);

    // Both caches request continuously for four transactions
`ifdef MEM_ARB_RR_EN
    exp_mem(2'b01, 28'h70, WD50); exp_rsp(1'b1, D70);
    exp_mem(2'b01, 28'h80, WI);   exp_rsp(1'b0, D80);
    exp_mem(2'b01, 28'h70, WD50); exp_rsp(1'b1, D70);
    exp_mem(2'b01, 28'h80, WI);   exp_rsp(1'b0, D80);
`else
    for (int k = 0; k < 4; k++) begin
      exp_mem(2'b01, 28'h70, WD50);
      exp_rsp(1'b1, D70);
    end
`endif
    d_mem_addr = 28'h70; d_mem_read = 1'b1;
    i_mem_addr = 28'h80; i_mem_read = 1'b1;
    service(4, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    probe(P_IDLE);
    probe(P_DRAIN);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
